// File: rtl/card_datapath.sv
// Card-holding datapath for the baccarat engine: six card slots, hand scores,
// seven-segment displays and debug status (dealt-card count, sticky error).
module card_datapath (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] new_card,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
  output logic [3:0] pcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic [2:0] cards_dealt,
  output logic       card_error
);

  logic [3:0] p1_q, p2_q, p3_q, d1_q, d2_q, d3_q;
  logic [2:0] dealt_q;
  logic       error_q;
  logic       card_ok;
  logic       any_load;
  logic [3:0] load_val;
  logic [4:0] psum, dsum;

  // Baccarat point value: face value for A..9, zero for tens, faces and empty.
  function automatic logic [3:0] card_value(input logic [3:0] c);
    return ((c >= 4'd1) && (c <= 4'd9)) ? c : 4'd0;
  endfunction

  // Active-low segment pattern, bit order {g,f,e,d,c,b,a}; empty/illegal blanks.
  function automatic logic [6:0] seg(input logic [3:0] c);
    logic [6:0] s;
    case (c)
      4'd1:    s = 7'b0001000;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      4'd10:   s = 7'b1000000;
      4'd11:   s = 7'b1100001;
      4'd12:   s = 7'b0011000;
      4'd13:   s = 7'b0001001;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Qualify the incoming card; illegal codes are stored as an empty slot.
  always_comb begin
    card_ok  = (new_card >= 4'd1) && (new_card <= 4'd13);
    load_val = card_ok ? new_card : 4'd0;
    any_load = load_pcard1 | load_pcard2 | load_pcard3 |
               load_dcard1 | load_dcard2 | load_dcard3;
  end

  // Slot registers and debug status; every addressed slot takes the same card.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      p1_q    <= 4'd0;
      p2_q    <= 4'd0;
      p3_q    <= 4'd0;
      d1_q    <= 4'd0;
      d2_q    <= 4'd0;
      d3_q    <= 4'd0;
      dealt_q <= 3'd0;
      error_q <= 1'b0;
    end else begin
      if (load_pcard1) p1_q <= load_val;
      if (load_pcard2) p2_q <= load_val;
      if (load_pcard3) p3_q <= load_val;
      if (load_dcard1) d1_q <= load_val;
      if (load_dcard2) d2_q <= load_val;
      if (load_dcard3) d3_q <= load_val;
      // One count per loading cycle, saturating at a full six-card round.
      if (any_load && (dealt_q != 3'd6)) dealt_q <= dealt_q + 3'd1;
      if (any_load && !card_ok) error_q <= 1'b1;
    end
  end

  // Hand scores straight from the slots; max sum 27 fits in 5 bits.
  always_comb begin
    psum   = 5'(card_value(p1_q)) + 5'(card_value(p2_q)) + 5'(card_value(p3_q));
    dsum   = 5'(card_value(d1_q)) + 5'(card_value(d2_q)) + 5'(card_value(d3_q));
    pscore = 4'(psum % 5'd10);
    dscore = 4'(dsum % 5'd10);
  end

  // Displays and raw outputs.
  always_comb begin
    HEX0        = seg(p1_q);
    HEX1        = seg(p2_q);
    HEX2        = seg(p3_q);
    HEX3        = seg(d1_q);
    HEX4        = seg(d2_q);
    HEX5        = seg(d3_q);
    pcard3      = p3_q;
    cards_dealt = dealt_q;
    card_error  = error_q;
  end

endmodule

// File: tb/tb_card_datapath.sv
// Bench for card_datapath: directed scenarios plus randomized deals checked
// against a card-level model of the six slots.
module tb_card_datapath;

  logic       slow_clock = 1'b0;
  logic       resetb = 1'b0;
  logic [3:0] new_card = 4'd0;
  logic [5:0] ld = 6'd0;  // {D3,D2,D1,P3,P2,P1}
  logic [3:0] pcard3, pscore, dscore;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [2:0] cards_dealt;
  logic       card_error;

  int vectors = 0;
  int miscompares = 0;

  // Model: slot[0..2] = P1..P3, slot[3..5] = D1..D3.
  int m_slot[6];
  int m_count;
  bit m_err;

  logic [6:0] hex_obs[6];
  assign hex_obs[0] = HEX0;
  assign hex_obs[1] = HEX1;
  assign hex_obs[2] = HEX2;
  assign hex_obs[3] = HEX3;
  assign hex_obs[4] = HEX4;
  assign hex_obs[5] = HEX5;

  card_datapath dut (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .new_card   (new_card),
    .load_pcard1(ld[0]),
    .load_pcard2(ld[1]),
    .load_pcard3(ld[2]),
    .load_dcard1(ld[3]),
    .load_dcard2(ld[4]),
    .load_dcard3(ld[5]),
    .pcard3     (pcard3),
    .pscore     (pscore),
    .dscore     (dscore),
    .HEX0       (HEX0),
    .HEX1       (HEX1),
    .HEX2       (HEX2),
    .HEX3       (HEX3),
    .HEX4       (HEX4),
    .HEX5       (HEX5),
    .cards_dealt(cards_dealt),
    .card_error (card_error)
  );

  always #5 slow_clock = ~slow_clock;

  function automatic int value_of(input int c);
    return (c >= 1 && c <= 9) ? c : 0;
  endfunction

  function automatic int hand(input int base);
    return (value_of(m_slot[base]) + value_of(m_slot[base+1]) + value_of(m_slot[base+2])) % 10;
  endfunction

  function automatic logic [6:0] disp(input int c);
    logic [6:0] tab[14];
    tab[0] = 7'b1111111;  tab[1] = 7'b0001000;  tab[2] = 7'b0100100;
    tab[3] = 7'b0110000;  tab[4] = 7'b0011001;  tab[5] = 7'b0010010;
    tab[6] = 7'b0000010;  tab[7] = 7'b1111000;  tab[8] = 7'b0000000;
    tab[9] = 7'b0010000;  tab[10] = 7'b1000000; tab[11] = 7'b1100001;
    tab[12] = 7'b0011000; tab[13] = 7'b0001001;
    return (c >= 0 && c <= 13) ? tab[c] : 7'b1111111;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_slot[i] = 0;
    m_count = 0;
    m_err = 0;
  endtask

  // Async reset mid-cycle, released on a falling edge so the next rising edge can load.
  task automatic do_reset();
    @(negedge slow_clock);
    #2 resetb = 1'b0;
    model_reset();
    #1;
    @(negedge slow_clock);
    resetb = 1'b1;
  endtask

  // One cycle of stimulus: drive after a falling edge, let a rising edge pass, update model.
  task automatic apply(input logic [5:0] strobes, input logic [3:0] card);
    int v;
    @(negedge slow_clock);
    ld = strobes;
    new_card = card;
    @(posedge slow_clock);
    #1;
    if (strobes != 0) begin
      v = (card >= 1 && card <= 13) ? int'(card) : 0;
      if (v == 0) m_err = 1;
      for (int i = 0; i < 6; i++) if (strobes[i]) m_slot[i] = v;
      if (m_count < 6) m_count++;
    end
    ld = 6'd0;
  endtask

  task automatic test_reset();
    @(negedge slow_clock);
    vectors++;
    if (cards_dealt !== 3'd0 || card_error !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_status: got dealt=%0d err=%b, want 0/0", cards_dealt, card_error);
    end
    vectors++;
    if (pscore !== 4'd0 || dscore !== 4'd0 || pcard3 !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_scores: got p=%0d d=%0d pc3=%0d, want 0", pscore, dscore, pcard3);
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (hex_obs[i] !== 7'b1111111) begin
        miscompares++;
        $display("FAIL reset_hex%0d: got %b, want 1111111", i, hex_obs[i]);
      end
    end
    @(negedge slow_clock);
    resetb = 1'b1;
    model_reset();
  endtask

  task automatic test_standard_deal();
    do_reset();
    apply(6'b000001, 4'd7);
    apply(6'b001000, 4'd12);
    apply(6'b000010, 4'd5);
    apply(6'b010000, 4'd3);
    vectors++;
    if (pscore !== 4'd2 || dscore !== 4'd3) begin
      miscompares++;
      $display("FAIL std_scores: got p=%0d d=%0d, want p=2 d=3", pscore, dscore);
    end
    vectors++;
    if (HEX0 !== 7'b1111000 || HEX3 !== 7'b0011000) begin
      miscompares++;
      $display("FAIL std_hex: got HEX0=%b HEX3=%b, want 1111000 0011000", HEX0, HEX3);
    end
    vectors++;
    if (cards_dealt !== 3'd4) begin
      miscompares++;
      $display("FAIL std_dealt: got %0d, want 4", cards_dealt);
    end
  endtask

  task automatic test_third_cards();
    apply(6'b000100, 4'd9);
    apply(6'b100000, 4'd13);
    vectors++;
    if (pscore !== 4'd1 || dscore !== 4'd3 || pcard3 !== 4'd9) begin
      miscompares++;
      $display("FAIL third_scores: got p=%0d d=%0d pc3=%0d, want 1 3 9", pscore, dscore, pcard3);
    end
    vectors++;
    if (HEX2 !== 7'b0010000 || HEX5 !== 7'b0001001) begin
      miscompares++;
      $display("FAIL third_hex: got HEX2=%b HEX5=%b, want 0010000 0001001", HEX2, HEX5);
    end
    vectors++;
    if (cards_dealt !== 3'd6) begin
      miscompares++;
      $display("FAIL third_dealt: got %0d, want 6", cards_dealt);
    end
    apply(6'b000001, 4'd2);
    vectors++;
    if (cards_dealt !== 3'd6 || pscore !== 4'd6) begin
      miscompares++;
      $display("FAIL saturate: got dealt=%0d p=%0d, want 6 6", cards_dealt, pscore);
    end
  endtask

  task automatic test_face_cards();
    do_reset();
    apply(6'b000001, 4'd10);
    apply(6'b000010, 4'd11);
    apply(6'b000100, 4'd13);
    vectors++;
    if (pscore !== 4'd0) begin
      miscompares++;
      $display("FAIL face_score: got %0d, want 0", pscore);
    end
    vectors++;
    if (HEX0 !== 7'b1000000 || HEX1 !== 7'b1100001 || HEX2 !== 7'b0001001) begin
      miscompares++;
      $display("FAIL face_hex: got %b %b %b, want 1000000 1100001 0001001", HEX0, HEX1, HEX2);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    apply(6'b001001, 4'd4);
    vectors++;
    if (pscore !== 4'd4 || dscore !== 4'd4 || cards_dealt !== 3'd1) begin
      miscompares++;
      $display("FAIL simul: got p=%0d d=%0d dealt=%0d, want 4 4 1", pscore, dscore, cards_dealt);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    apply(6'b001000, 4'd6);
    apply(6'b010000, 4'd15);
    vectors++;
    if (dscore !== 4'd6 || HEX4 !== 7'b1111111 || card_error !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal: got d=%0d HEX4=%b err=%b, want 6 1111111 1", dscore, HEX4, card_error);
    end
    apply(6'b000001, 4'd3);
    vectors++;
    if (card_error !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky: got %b, want 1", card_error);
    end
  endtask

  task automatic test_reset_mid_round();
    apply(6'b000011, 4'd8);
    @(negedge slow_clock);
    #2 resetb = 1'b0;
    #1;
    vectors++;
    if (pscore !== 4'd0 || dscore !== 4'd0 || cards_dealt !== 3'd0 || card_error !== 1'b0 ||
        HEX0 !== 7'b1111111 || HEX3 !== 7'b1111111 || HEX4 !== 7'b1111111) begin
      miscompares++;
      $display("FAIL midreset: got p=%0d d=%0d dealt=%0d err=%b HEX0=%b HEX4=%b, want cleared",
               pscore, dscore, cards_dealt, card_error, HEX0, HEX4);
    end
    model_reset();
    @(negedge slow_clock);
    resetb = 1'b1;
  endtask

  task automatic test_random();
    logic [5:0] s;
    logic [3:0] c;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      s = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'(1 << $urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0) s = 6'($urandom);
      c = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(1, 13));
      apply(s, c);
      vectors++;
      if (pscore !== 4'(hand(0)) || dscore !== 4'(hand(3)) || pcard3 !== 4'(m_slot[2])) begin
        miscompares++;
        $display("FAIL rand_score[%0d]: got p=%0d d=%0d pc3=%0d, want %0d %0d %0d",
                 n, pscore, dscore, pcard3, hand(0), hand(3), m_slot[2]);
      end
      vectors++;
      if (cards_dealt !== 3'(m_count) || card_error !== m_err) begin
        miscompares++;
        $display("FAIL rand_status[%0d]: got dealt=%0d err=%b, want %0d %b",
                 n, cards_dealt, card_error, m_count, m_err);
      end
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (hex_obs[i] !== disp(m_slot[i])) begin
          miscompares++;
          $display("FAIL rand_hex%0d[%0d]: got %b, want %b", i, n, hex_obs[i], disp(m_slot[i]));
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_standard_deal();
    test_third_cards();
    test_face_cards();
    test_simultaneous();
    test_illegal();
    test_reset_mid_round();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
